// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared definitions for the multiplexed 7-segment scanner.
//               Holds the segment bit positions on the segment bus and the
//               16-entry hex glyph table, plus a lookup helper.
//               Glyphs are active-high; bit0..bit6 = a..g.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Bit positions on the 8-bit segment bus
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef logic [6:0] glyph_t;
    typedef logic [7:0] segbus_t;

    // Glyph for nibble n sits at bits [7n+6:7n]; entry F is the leftmost.
    //                                       F      E      d      C      b      A
    localparam logic [16*7-1:0] SEG_HEX_TABLE = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77,
    //                                       9      8      7      6      5      4
                                             7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66,
    //                                       3      2      1      0
                                             7'h4F, 7'h5B, 7'h06, 7'h3F};

    function automatic glyph_t seg_hex(input logic [3:0] nib);
        return SEG_HEX_TABLE[7*nib +: 7];
    endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_decode
// Description : Combinational hex nibble to 7-segment glyph decode.
//               Output is active-high (1 = segment lit); polarity is applied
//               by the instantiating block at its output registers.
// Ports       : nibble [3:0] in  - hex digit 0..F
//               seg7   [6:0] out - segments a..g (bit0 = a)
// Revision    : 1.0 - initial release
// ============================================================================
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg7
);

    assign seg7 = seg_hex(nibble);

endmodule : seg_decode
`default_nettype wire

// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan
// Description : Multiplexed 7-segment display scanner. A prescaler divides
//               clk into digit slots of SCAN_DIV cycles; the first cycle of
//               each slot is dead time (all digits and segments off) to stop
//               ghosting, the remaining cycles light the selected digit.
//               Display data is double-buffered: loads go to a pending
//               buffer that is committed at the frame boundary, so a frame
//               never shows a mix of old and new data.
// Build option: define SEG_LZB_EN to enable leading-zero blanking.
// Ports       : clk                  in  - clock, rising edge
//               rst_n                in  - asynchronous active-low reset
//               en                   in  - scan enable
//               load                 in  - strobe capturing value/dp/blank
//               value [4*ND-1:0]     in  - hex nibbles, digit 0 rightmost
//               dp    [ND-1:0]       in  - per-digit decimal point
//               blank [ND-1:0]       in  - per-digit force-off
//               dig   [ND-1:0]       out - one-hot digit select, registered
//               seg   [7:0]          out - segments a..g, dp, registered
//               frame_done           out - one-cycle pulse after each frame
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 1000,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   dig,
    output logic [7:0]              seg,
    output logic                    frame_done
);

    localparam int PW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] c_PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] c_IDX_LAST   = IW'(NUM_DIGITS - 1);

    // XOR masks: "off" pattern after polarity, also the reset value
    localparam logic [NUM_DIGITS-1:0] c_DIG_OFF = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [7:0]            c_SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_act_val;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic                    r_pend_valid;
    logic                    r_frame_done;
    logic [NUM_DIGITS-1:0]   r_dig;
    logic [7:0]              r_seg;

    logic                    w_tc;
    logic                    w_frame_end;
    logic [NUM_DIGITS-1:0]   w_lzb;
    logic [3:0]              w_sel_nib;
    logic                    w_sel_dp;
    logic                    w_sel_blank;
    logic                    w_sel_lzb;
    glyph_t                  w_glyph;
    logic [NUM_DIGITS-1:0]   w_dig_hi;
    segbus_t                 w_seg_hi;

    assign w_tc        = en && (r_presc == c_PRESC_LAST);
    assign w_frame_end = w_tc && (r_idx == c_IDX_LAST);

    // ------------------------------------------------------------------------
    // Prescaler and digit index. Held at zero while disabled so that a
    // rising en always starts at slot 0, cycle 0.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (!en) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tc) begin
            r_presc <= '0;
            r_idx   <= (r_idx == c_IDX_LAST) ? '0 : r_idx + IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Display buffers. A load on the boundary cycle itself bypasses pending
    // and supersedes anything already waiting there.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_val    <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_valid <= 1'b0;
        end else if (!en) begin
            // Not scanning: no frame boundary will come, so write through.
            // Stale pending data is dropped so it cannot overwrite this load.
            if (load) begin
                r_act_val    <= value;
                r_act_dp     <= dp;
                r_act_blank  <= blank;
                r_pend_valid <= 1'b0;
            end
        end else if (w_frame_end) begin
            if (load) begin
                r_act_val    <= value;
                r_act_dp     <= dp;
                r_act_blank  <= blank;
                r_pend_valid <= 1'b0;
            end else if (r_pend_valid) begin
                r_act_val    <= r_pend_val;
                r_act_dp     <= r_pend_dp;
                r_act_blank  <= r_pend_blank;
                r_pend_valid <= 1'b0;
            end
        end else if (load) begin
            r_pend_val   <= value;
            r_pend_dp    <= dp;
            r_pend_blank <= blank;
            r_pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
        end
    end

    // ------------------------------------------------------------------------
    // Leading-zero blanking: a digit is blanked when it and every digit to
    // its left are zero. Digit 0 is exempt so a zero value still shows "0".
    // ------------------------------------------------------------------------
`ifdef SEG_LZB_EN
    always_comb begin
        logic v_run;
        w_lzb = '0;
        v_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_run    = v_run & (r_act_val[4*i +: 4] == 4'h0);
            w_lzb[i] = v_run;
        end
    end
`else
    assign w_lzb = '0;
`endif

    // ------------------------------------------------------------------------
    // Select the current digit's data; one decoder serves all digits
    // ------------------------------------------------------------------------
    always_comb begin
        w_sel_nib   = 4'h0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b0;
        w_sel_lzb   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_sel_nib   = r_act_val[4*i +: 4];
                w_sel_dp    = r_act_dp[i];
                w_sel_blank = r_act_blank[i];
                w_sel_lzb   = w_lzb[i];
            end
        end
    end

    seg_decode u_decode (
        .nibble (w_sel_nib),
        .seg7   (w_glyph)
    );

    // ------------------------------------------------------------------------
    // Active-high output pattern for the current prescaler/index state.
    // Cycle 0 of each slot is dead time.
    // ------------------------------------------------------------------------
    always_comb begin
        w_dig_hi = '0;
        w_seg_hi = '0;
        if (en && (r_presc != '0)) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                w_dig_hi[i] = (r_idx == IW'(i));
            end
            // blank kills the dp too; LZB only hides the glyph
            if (!w_sel_blank) begin
                w_seg_hi[SEG_DP] = w_sel_dp;
                if (!w_sel_lzb) begin
                    w_seg_hi[SEG_G:SEG_A] = w_glyph;
                end
            end
        end
    end

    // Polarity is applied only here, at the pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dig <= c_DIG_OFF;
            r_seg <= c_SEG_OFF;
        end else begin
            r_dig <= w_dig_hi ^ c_DIG_OFF;
            r_seg <= w_seg_hi ^ c_SEG_OFF;
        end
    end

    assign dig        = r_dig;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule : seg_scan
`default_nettype wire
